// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB byte-FIFO peripheral.
//   - register offsets (word aligned, PADDR[1:0] dropped before compare)
//   - bit positions inside the FIFO status register
//   - APB responder FSM state encoding
package apb_fifo_pkg;

    localparam logic [3:0] FSR_OFS  = 4'h0;
    localparam logic [3:0] FWDR_OFS = 4'h4;
    localparam logic [3:0] FRDR_OFS = 4'h8;

    localparam int EMPTY_B = 0;
    localparam int FULL_B  = 1;
    localparam int OVF_B   = 2;
    localparam int UNF_B   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } fsm_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO.
// Ports:
//   clk, reset      clock and asynchronous active-high reset (pointers/count only)
//   push, wdata     enqueue wdata; ignored while full
//   pop             dequeue head entry; ignored while empty
//   rdata           head entry, combinational (undefined content while empty)
//   full, empty     occupancy flags
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset: after reset the old entries are simply unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB responder exposing a byte FIFO through three word registers.
//   0x0 FSR  R: {UNF, OVF, full, empty}  W: 1-to-clear (bit2 OVF, bit3 UNF)
//   0x4 FWDR W: push PWDATA[DATA_W-1:0]  R: 0
//   0x8 FRDR R: pop, zero-extended        W: ignored
//   0xC      unmapped, reads 0
// Every transfer takes exactly one wait state: the action happens on the edge
// that ends the first access cycle, and PREADY is high for the second.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA                           APB request
//   PRDATA, PREADY                   APB response (registered)
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY
);

    fsm_e              state;
    logic              ovf;
    logic              unf;
    logic [3:0]        addr;
    logic              act;
    logic              push;
    logic              pop;
    logic              fsr_wr;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fsr;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign addr   = {PADDR[3:2], 2'b00};
    // Only the first access cycle acts; the PREADY cycle must not repeat it.
    assign act    = (state == IDLE) & PSEL & PENABLE & ~PREADY;
    assign push   = act &  PWRITE & (addr == FWDR_OFS);
    assign pop    = act & ~PWRITE & (addr == FRDR_OFS);
    assign fsr_wr = act &  PWRITE & (addr == FSR_OFS);

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (PWDATA[DATA_W-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        fsr          = '0;
        fsr[EMPTY_B] = fifo_empty;
        fsr[FULL_B]  = fifo_full;
        fsr[OVF_B]   = ovf;
        fsr[UNF_B]   = unf;
    end

    // Read mux, sampled on the action edge (pre-update state).
    always_comb begin
        rd_val = '0;
        if (!PWRITE) begin
            case (addr)
                FSR_OFS:  rd_val = fsr;
                FRDR_OFS: rd_val = fifo_empty ? 32'h0 : 32'(fifo_rdata);
                default:  rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            PREADY <= 1'b0;
            PRDATA <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (act) begin
                        state  <= ACK;
                        PREADY <= 1'b1;
                        PRDATA <= rd_val;
                        if (push && fifo_full) ovf <= 1'b1;
                        if (pop && fifo_empty) unf <= 1'b1;
                        if (fsr_wr) begin
                            if (PWDATA[OVF_B]) ovf <= 1'b0;
                            if (PWDATA[UNF_B]) unf <= 1'b0;
                        end
                    end
                end
                // Return unconditionally, even if the master already dropped PSEL.
                ACK: begin
                    state  <= IDLE;
                    PREADY <= 1'b0;
                    PRDATA <= '0;
                end
                default: begin
                    state  <= IDLE;
                    PREADY <= 1'b0;
                    PRDATA <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: directed register-map scenarios with literal
// expectations, then randomized APB traffic against a queue-based model.
// A single compare process checks PREADY/PRDATA every cycle.
module tb_apb_fifo_slave;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    always #5 clk = ~clk;

    apb_fifo_slave #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  q[$];
    bit          m_ovf;
    bit          m_unf;
    logic        exp_pready;
    logic [31:0] exp_prdata;
    bit          cmp_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("pready", {31'b0, PREADY}, {31'b0, exp_pready});
            check("prdata", PRDATA, exp_prdata);
        end
    end

    function automatic void model_reset();
        q.delete();
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        exp_pready = 1'b0;
        exp_prdata = 32'h0;
    endfunction

    // One complete transfer in register-map terms; returns the read data.
    function automatic logic [31:0] model_xfer(input logic wr, input logic [3:0] addr,
                                               input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0;
        case (addr & 4'hC)
            4'h0: begin
                if (wr) begin
                    if (wd[2]) m_ovf = 1'b0;
                    if (wd[3]) m_unf = 1'b0;
                end else begin
                    r = {28'b0, m_unf, m_ovf, q.size() == DEPTH, q.size() == 0};
                end
            end
            4'h4: begin
                if (wr) begin
                    if (q.size() == DEPTH) m_ovf = 1'b1;
                    else q.push_back(wd[7:0]);
                end
            end
            4'h8: begin
                if (!wr) begin
                    if (q.size() == 0) m_unf = 1'b1;
                    else r = {24'b0, q.pop_front()};
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Starts at posedge+1, ends at posedge+1 back in IDLE (back-to-back capable).
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] dut_rd, output logic [31:0] mdl_rd);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wd;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        mdl_rd     = model_xfer(wr, addr, wd);
        exp_pready = 1'b1;
        exp_prdata = mdl_rd;
        dut_rd     = PRDATA;
        @(posedge clk); #1;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        exp_pready = 1'b0;
        exp_prdata = 32'h0;
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] x, y;
        xfer(1'b1, a, d, x, y);
    endtask

    task automatic do_rd(input string nm, input logic [3:0] a, input logic [31:0] lit);
        logic [31:0] x, y;
        xfer(1'b0, a, 32'h0, x, y);
        check({nm, " dut"}, x, lit);
        check({nm, " model"}, y, lit);
    endtask

    initial begin
        reset   = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 4'h0;
        PWDATA  = 32'h0;
        cmp_en  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset pready", {31'b0, PREADY}, 32'h0);
        check("reset prdata", PRDATA, 32'h0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Reset state and basic push/pop.
        do_rd("fsr after reset", 4'h0, 32'h1);
        do_wr(4'h4, 32'hA5);
        do_rd("pop a5", 4'h8, 32'hA5);
        do_rd("fsr empty again", 4'h0, 32'h1);

        // Fill (pointers now offset by one, so this wraps), overflow, drain.
        for (int i = 0; i < 8; i++) do_wr(4'h4, 32'h10 + i);
        do_rd("fsr full", 4'h0, 32'h2);
        do_wr(4'h4, 32'hFF);
        do_rd("fsr full ovf", 4'h0, 32'h6);
        for (int i = 0; i < 8; i++) do_rd("pop seq", 4'h8, 32'h10 + i);
        do_rd("fsr empty ovf", 4'h0, 32'h5);
        do_wr(4'h0, 32'h4);
        do_rd("fsr ovf cleared", 4'h0, 32'h1);

        // Underflow and W1C behaviour.
        do_rd("pop empty", 4'h8, 32'h0);
        do_rd("fsr unf", 4'h0, 32'h9);
        do_wr(4'h0, 32'h8);
        do_rd("fsr unf cleared", 4'h0, 32'h1);
        do_rd("pop empty again", 4'h8, 32'h0);
        do_wr(4'h0, 32'h4);
        do_rd("fsr unf kept", 4'h0, 32'h9);
        do_wr(4'h0, 32'hC);
        do_rd("fsr both cleared", 4'h0, 32'h1);

        // Single push per transfer, unmapped and write-only/read-only slots.
        do_wr(4'h4, 32'h33);
        do_rd("fsr one entry", 4'h0, 32'h0);
        do_rd("read 0xc", 4'hC, 32'h0);
        do_wr(4'hC, 32'hFFFF_FFFF);
        do_rd("fsr after 0xc wr", 4'h0, 32'h0);
        do_rd("read fwdr", 4'h4, 32'h0);
        do_wr(4'h8, 32'h44);
        do_rd("fsr after frdr wr", 4'h0, 32'h0);
        do_rd("pop 33", 4'h9, 32'h33);
        do_rd("fsr empty low bits", 4'h3, 32'h1);

        // Reset during the PREADY=0 access cycle of a push.
        do_wr(4'h4, 32'h55);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h77;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("rst mid pready", {31'b0, PREADY}, 32'h0);
        check("rst mid prdata", PRDATA, 32'h0);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_rd("fsr after mid rst", 4'h0, 32'h1);

        // Reset during the PREADY=1 cycle of an FSR read.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        check("ack pready", {31'b0, PREADY}, 32'h1);
        check("ack prdata", PRDATA, 32'h1);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("rst ack pready", {31'b0, PREADY}, 32'h0);
        check("rst ack prdata", PRDATA, 32'h0);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; reset = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int          op;
            int          idle;
            logic [3:0]  base;
            logic        wr;
            logic [31:0] wd, x, y;
            op   = $urandom_range(0, 9);
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                PSEL    = 1'($urandom_range(0, 1));
                PENABLE = PSEL ? 1'b0 : 1'($urandom_range(0, 1));
                PWRITE  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            PSEL = 1'b0; PENABLE = 1'b0;
            wd = $urandom;
            if (op < 4)       begin base = 4'h4; wr = 1'b1; end
            else if (op < 7)  begin base = 4'h8; wr = 1'b0; end
            else if (op == 7) begin base = 4'h0; wr = 1'b0; end
            else if (op == 8) begin base = 4'h0; wr = 1'b1; wd = wd & 32'hC; end
            else begin
                base = {2'($urandom_range(0, 3)), 2'b00};
                wr   = 1'($urandom_range(0, 1));
            end
            xfer(wr, base | 4'($urandom_range(0, 3)), wd, x, y);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
